// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with stall, flush, ALU-control decode and bubble counter
module idex_pipe_reg #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] iimm_i,
  input  logic [XLEN-1:0] simm_i,
  input  logic [RA_W-1:0] rs1_addr_i,
  input  logic [RA_W-1:0] rs2_addr_i,
  input  logic [RA_W-1:0] rd_addr_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic            regwrite_i,
  input  logic [1:0]      memctl_i,
  input  logic [1:0]      aluop_i,
  input  logic            alusrc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] val1_o,
  output logic [XLEN-1:0] val2_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] simm_o,
  output logic [RA_W-1:0] rs1_addr_o,
  output logic [RA_W-1:0] rs2_addr_o,
  output logic [RA_W-1:0] rd_addr_o,
  output logic            regwrite_o,
  output logic [1:0]      memctl_o,
  output logic [3:0]      aluctrl_o,
  output logic            illegal_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND = 4'b0000, OR = 4'b0001, XOR = 4'b0011;
  localparam logic [3:0] SLL = 4'b0100, SRL = 4'b0101, SRA = 4'b0111, SLT = 4'b1000, MUL = 4'b1111;
  logic [3:0] alu_d;
  logic       ill_d;
  logic       bubble;
  always_comb begin
    alu_d = ADD;
    ill_d = 1'b0;
    case (aluop_i)
      2'b00: alu_d = ADD;
      2'b01: alu_d = SUB;
      2'b10:
        case ({funct7_i, funct3_i})
          10'b0000000_000: alu_d = ADD;
          10'b0100000_000: alu_d = SUB;
          10'b0000000_111: alu_d = AND;
          10'b0000000_110: alu_d = OR;
          10'b0000000_100: alu_d = XOR;
          10'b0000000_001: alu_d = SLL;
          10'b0000000_101: alu_d = SRL;
          10'b0100000_101: alu_d = SRA;
          10'b0000000_010: alu_d = SLT;
          10'b0000001_000: alu_d = MUL;
          default:         ill_d = 1'b1;
        endcase
      default:
        case (funct3_i)
          3'b000:  alu_d = ADD;
          3'b111:  alu_d = AND;
          3'b110:  alu_d = OR;
          3'b100:  alu_d = XOR;
          3'b010:  alu_d = SLT;
          3'b001:  alu_d = SLL;
          3'b101:  alu_d = funct7_i[5] ? SRA : SRL;
          default: ill_d = 1'b1;
        endcase
    endcase
  end
  // A non-valid ID slot is a bubble unless the stage is stalled; flush always wins.
  assign bubble = flush_i | (~stall_i & ~valid_i);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o      <= 1'b0;
      val1_o       <= '0;
      val2_o       <= '0;
      rs2_data_o   <= '0;
      simm_o       <= '0;
      rs1_addr_o   <= '0;
      rs2_addr_o   <= '0;
      rd_addr_o    <= '0;
      regwrite_o   <= 1'b0;
      memctl_o     <= '0;
      aluctrl_o    <= '0;
      illegal_o    <= 1'b0;
      bubble_cnt_o <= '0;
    end else if (bubble) begin
      valid_o      <= 1'b0;
      val1_o       <= '0;
      val2_o       <= '0;
      rs2_data_o   <= '0;
      simm_o       <= '0;
      rs1_addr_o   <= '0;
      rs2_addr_o   <= '0;
      rd_addr_o    <= '0;
      regwrite_o   <= 1'b0;
      memctl_o     <= '0;
      aluctrl_o    <= ADD;
      illegal_o    <= 1'b0;
      bubble_cnt_o <= (&bubble_cnt_o) ? bubble_cnt_o : bubble_cnt_o + 1'b1;
    end else if (!stall_i) begin
      valid_o      <= 1'b1;
      val1_o       <= rs1_data_i;
      val2_o       <= alusrc_i ? iimm_i : rs2_data_i;
      rs2_data_o   <= rs2_data_i;
      simm_o       <= simm_i;
      rs1_addr_o   <= rs1_addr_i;
      rs2_addr_o   <= rs2_addr_i;
      rd_addr_o    <= rd_addr_i;
      regwrite_o   <= regwrite_i;
      memctl_o     <= memctl_i;
      aluctrl_o    <= alu_d;
      illegal_o    <= ill_d;
    end
  end
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed scoreboard bench for idex_pipe_reg, plus a 2-bit-counter instance for saturation
module tb_idex_pipe_reg;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic stall_i, flush_i, valid_i, flush2;
  logic [31:0] rs1_data_i, rs2_data_i, iimm_i, simm_i;
  logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic regwrite_i, alusrc_i;
  logic [1:0] memctl_i, aluop_i;
  logic valid_o, regwrite_o, illegal_o;
  logic [31:0] val1_o, val2_o, rs2_data_o, simm_o;
  logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [1:0] memctl_o;
  logic [3:0] aluctrl_o;
  logic [15:0] bubble_cnt_o;
  logic v2, rw2, il2;
  logic [31:0] a2, b2, r22, s22;
  logic [4:0] x2, y2, z2;
  logic [1:0] m2, cnt2;
  logic [3:0] ac2;

  typedef struct packed {
    logic v; logic [31:0] v1, v2, r2, si; logic [4:0] a1, a2, ad;
    logic rw; logic [1:0] mc; logic [3:0] ac; logic il; logic [15:0] cnt;
  } exp_t;
  exp_t m, obs, e;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  assign obs = {valid_o, val1_o, val2_o, rs2_data_o, simm_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
                regwrite_o, memctl_o, aluctrl_o, illegal_o, bubble_cnt_o};

  idex_pipe_reg dut (
    .clk_i, .rst_i, .stall_i, .flush_i, .valid_i, .rs1_data_i, .rs2_data_i, .iimm_i, .simm_i,
    .rs1_addr_i, .rs2_addr_i, .rd_addr_i, .funct3_i, .funct7_i, .regwrite_i, .memctl_i,
    .aluop_i, .alusrc_i, .valid_o, .val1_o, .val2_o, .rs2_data_o, .simm_o, .rs1_addr_o,
    .rs2_addr_o, .rd_addr_o, .regwrite_o, .memctl_o, .aluctrl_o, .illegal_o, .bubble_cnt_o);

  idex_pipe_reg #(.CNT_W(2)) dut2 (
    .clk_i, .rst_i, .stall_i(1'b0), .flush_i(flush2), .valid_i, .rs1_data_i, .rs2_data_i,
    .iimm_i, .simm_i, .rs1_addr_i, .rs2_addr_i, .rd_addr_i, .funct3_i, .funct7_i, .regwrite_i,
    .memctl_i, .aluop_i, .alusrc_i, .valid_o(v2), .val1_o(a2), .val2_o(b2), .rs2_data_o(r22),
    .simm_o(s22), .rs1_addr_o(x2), .rs2_addr_o(y2), .rd_addr_o(z2), .regwrite_o(rw2),
    .memctl_o(m2), .aluctrl_o(ac2), .illegal_o(il2), .bubble_cnt_o(cnt2));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t nxt(input exp_t c);
    exp_t r;
    logic [3:0] ac;
    logic il;
    r = c;
    ac = 4'b0010;
    il = 1'b0;
    if (flush_i || (!stall_i && !valid_i)) begin
      r = '0;
      r.ac = 4'b0010;
      r.cnt = (c.cnt == 16'hffff) ? c.cnt : c.cnt + 16'd1;
    end else if (!stall_i) begin
      if (aluop_i == 2'b01) ac = 4'b0110;
      else if (aluop_i == 2'b10) begin
        if (funct7_i == 7'h00 && funct3_i != 3'b011) ac = {4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011, 4'b0101, 4'b0001, 4'b0000} >> (4 * (7 - funct3_i));
        else if (funct7_i == 7'h20 && funct3_i == 3'b000) ac = 4'b0110;
        else if (funct7_i == 7'h20 && funct3_i == 3'b101) ac = 4'b0111;
        else if (funct7_i == 7'h01 && funct3_i == 3'b000) ac = 4'b1111;
        else il = 1'b1;
      end else if (aluop_i == 2'b11) begin
        if (funct3_i == 3'b011) il = 1'b1;
        else if (funct3_i == 3'b101) ac = funct7_i[5] ? 4'b0111 : 4'b0101;
        else ac = {4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0001, 4'b0000} >> (4 * (7 - funct3_i));
      end
      r.v = 1'b1; r.v1 = rs1_data_i; r.v2 = alusrc_i ? iimm_i : rs2_data_i; r.r2 = rs2_data_i;
      r.si = simm_i; r.a1 = rs1_addr_i; r.a2 = rs2_addr_i; r.ad = rd_addr_i; r.rw = regwrite_i;
      r.mc = memctl_i; r.ac = ac; r.il = il;
    end
    return r;
  endfunction

  task automatic step(input string tag);
    m = nxt(m);
    q.push_back(m);
    @(posedge clk_i);
    #1;
    e = q.pop_front();
    check(tag, obs, e);
  endtask

  task automatic rnd();
    rs1_data_i = $urandom; rs2_data_i = $urandom; iimm_i = $urandom; simm_i = $urandom;
    rs1_addr_i = 5'($urandom); rs2_addr_i = 5'($urandom); rd_addr_i = 5'($urandom);
    regwrite_i = 1'($urandom); memctl_i = 2'($urandom); alusrc_i = 1'($urandom);
  endtask

  initial begin
    logic [9:0] keys [10] = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h004, 10'h001, 10'h005, 10'h105, 10'h002, 10'h008};
    logic [1:0] sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    stall_i = 0; flush_i = 0; valid_i = 1; flush2 = 0; funct3_i = 0; funct7_i = 0; aluop_i = 0;
    rnd();
    m = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset", obs, '0);
    @(negedge clk_i) rst_i = 1;
    rs1_data_i = 5; rs2_data_i = 3; alusrc_i = 0; aluop_i = 2'b10; funct7_i = 7'b0100000; funct3_i = 3'b000;
    step("rtype");
    check("rtype_ac", aluctrl_o, 4'b0110);
    check("rtype_v1", val1_o, 5);
    check("rtype_v2", val2_o, 3);
    check("rtype_valid_ill", {valid_o, illegal_o}, 2'b10);
    aluop_i = 2'b11; alusrc_i = 1; funct3_i = 3'b101; iimm_i = 4; rs2_data_i = 99;
    step("itype");
    check("itype_ac", aluctrl_o, 4'b0111);
    check("itype_v2", val2_o, 4);
    check("itype_r2", rs2_data_o, 99);
    aluop_i = 2'b10;
    foreach (keys[i]) begin
      rnd();
      {funct7_i, funct3_i} = keys[i];
      step($sformatf("rkey%0d", i));
    end
    aluop_i = 2'b11;
    for (int f = 0; f < 8; f++) begin
      rnd();
      funct3_i = 3'(f); funct7_i = 7'($urandom);
      step($sformatf("ikey%0d", f));
    end
    aluop_i = 2'b00; rnd(); step("add");
    aluop_i = 2'b01; rnd(); step("sub");
    rnd(); rd_addr_i = 7; regwrite_i = 1;
    step("pre_stall");
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      rnd(); valid_i = 1'($urandom);
      step($sformatf("stall%0d", i));
      check("stall_rd", {rd_addr_o, regwrite_o}, {5'd7, 1'b1});
    end
    flush_i = 1;
    step("flush_stall");
    check("flush_fields", {valid_o, regwrite_o, rd_addr_o, bubble_cnt_o}, {1'b0, 1'b0, 5'd0, 16'd1});
    stall_i = 0; flush_i = 0; valid_i = 1; aluop_i = 2'b10; funct7_i = 7'b0000001; funct3_i = 3'b100;
    step("illegal");
    check("illegal_flag", {aluctrl_o, illegal_o}, {4'b0010, 1'b1});
    valid_i = 0;
    step("illegal_bubble");
    check("illegal_bubble_flag", {illegal_o, bubble_cnt_o}, {1'b0, 16'd2});
    valid_i = 1; flush_i = 1;
    step("flush_again");
    #2 rst_i = 0;
    #1;
    m = '0;
    check("async_reset", obs, '0);
    check("async_reset_cnt2", cnt2, 2'd0);
    flush_i = 0;
    @(negedge clk_i) rst_i = 1;
    flush2 = 1;
    foreach (sat[i]) begin
      @(posedge clk_i);
      #1;
      check($sformatf("sat%0d", i), cnt2, sat[i]);
    end
    flush2 = 0;
    rnd(); aluop_i = 2'b00;
    step("post_reset_load");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
